// File: rtl/sop_lut_sweeper.sv
// sop_lut_sweeper: run-time programmable truth-table evaluator with a
// backpressured sweep engine that walks every input and counts minterms.
module sop_lut_sweeper #(
   parameter int                   N_IN    = 3,
   parameter logic [2**N_IN-1:0]   TT_INIT = 8'b11000110
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tt_wr,
   input  logic [2**N_IN-1:0]   tt_data,
   input  logic                 eval_valid,
   input  logic [N_IN-1:0]      eval_in,
   output logic                 out_valid,
   output logic                 out_s,
   input  logic                 sweep_start,
   output logic                 busy,
   output logic                 sw_valid,
   input  logic                 sw_ready,
   output logic [N_IN-1:0]      sw_idx,
   output logic                 sw_s,
   output logic                 done,
   output logic [N_IN:0]        ones_count
);

   localparam logic [N_IN-1:0] IDX_LAST = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [2**N_IN-1:0]  tt;
   logic [N_IN-1:0]     idx;
   logic                idle;
   logic                beat;

   assign idle = (state == IDLE);
   assign beat = sw_valid & sw_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (sweep_start) state_nx = SWEEP;
         SWEEP:   if (sw_ready && idx == IDX_LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      sw_valid = 1'b0;
      done     = 1'b0;
      sw_idx   = idx;
      sw_s     = 1'b0;
      unique case (state)
         SWEEP: begin
            busy     = 1'b1;
            sw_valid = 1'b1;
            sw_s     = tt[idx];
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // A write on the start edge lands before the first beat reads tt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt         <= TT_INIT;
         idx        <= '0;
         ones_count <= '0;
      end else begin
         if (tt_wr && idle) tt <= tt_data;
         if (idle && sweep_start) begin
            idx        <= '0;
            ones_count <= '0;
         end else if (beat) begin
            idx        <= idx + N_IN'(1);
            ones_count <= ones_count + (N_IN+1)'(sw_s);
         end
      end
   end

   // Eval reads the table as it was before any same-edge write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_s     <= 1'b0;
      end else begin
         out_valid <= eval_valid;
         if (eval_valid) out_s <= tt[eval_in];
      end
   end

endmodule
